// File: rtl/dm_pkg.sv
// Shared defaults, store-buffer entry layout and drain-engine states
// for the data-memory stage with store buffer.
package dm_pkg;

  localparam int DM_DATA_W   = 16;
  localparam int DM_ADDR_W   = 8;
  localparam int DM_SB_DEPTH = 4;
  localparam int DM_WR_LAT   = 2;

  // Entry layout at the default widths; modules rebuild it at their own widths.
  typedef struct packed {
    logic [DM_ADDR_W-1:0] addr;
    logic [DM_DATA_W-1:0] data;
  } sb_entry_t;

  typedef enum logic [0:0] {
    D_IDLE  = 1'b0,
    D_WRITE = 1'b1
  } drain_state_t;

endpackage

// File: rtl/dm_store_buffer.sv
// Circular store buffer: program-ordered FIFO of pending stores with a
// combinational youngest-match lookup used for load forwarding.
module dm_store_buffer
  import dm_pkg::*;
#(
  parameter  int DATA_W   = DM_DATA_W,
  parameter  int ADDR_W   = DM_ADDR_W,
  parameter  int SB_DEPTH = DM_SB_DEPTH,
  localparam int PTR_W    = $clog2(SB_DEPTH),
  localparam int CNT_W    = $clog2(SB_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_lk_addr,
  output logic              o_lk_hit,
  output logic [DATA_W-1:0] o_lk_data,
  output logic [ADDR_W-1:0] o_head_addr,
  output logic [DATA_W-1:0] o_head_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_empty,
  output logic              o_full
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } slot_t;

  slot_t             r_slot [SB_DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  w_idx;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty     = (r_count == {CNT_W{1'b0}});
  assign o_full      = (r_count == CNT_W'(SB_DEPTH));
  assign o_count     = r_count;
  assign o_head_addr = r_slot[r_head].addr;
  assign o_head_data = r_slot[r_head].data;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      if (w_do_push) r_tail <= r_tail + PTR_W'(1);
      else           r_tail <= r_tail;
      if (w_do_pop)  r_head <= r_head + PTR_W'(1);
      else           r_head <= r_head;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_slot[r_tail] <= {i_push_addr, i_push_data};
  end

  // Walk oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    o_lk_hit  = 1'b0;
    o_lk_data = {DATA_W{1'b0}};
    w_idx     = {PTR_W{1'b0}};
    for (int i = 0; i < SB_DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_slot[w_idx].addr == i_lk_addr)) begin
        o_lk_hit  = 1'b1;
        o_lk_data = r_slot[w_idx].data;
      end else begin
        o_lk_hit  = o_lk_hit;
        o_lk_data = o_lk_data;
      end
    end
  end

endmodule

// File: rtl/dm_block_sb.sv
// Data-memory stage: store buffer with load forwarding, multi-cycle drain
// engine committing the buffer head into the data array, and the ans_dm register.
module dm_block_sb
  import dm_pkg::*;
#(
  parameter  int DATA_W   = DM_DATA_W,
  parameter  int ADDR_W   = DM_ADDR_W,
  parameter  int SB_DEPTH = DM_SB_DEPTH,
  parameter  int WR_LAT   = DM_WR_LAT,
  localparam int CNT_W    = $clog2(SB_DEPTH + 1),
  localparam int WC_W     = (WR_LAT > 1) ? $clog2(WR_LAT) : 1,
  localparam int MEM_D    = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] DM_data,
  input  logic              mem_en_ex,
  input  logic              mem_rw_ex,
  input  logic              mem_mux_sel_dm,
  output logic [DATA_W-1:0] ans_dm,
  output logic              stall_dm,
  output logic [CNT_W-1:0]  sb_count,
  output logic              sb_empty
);

  logic [DATA_W-1:0] r_mem [MEM_D];
  drain_state_t      r_state;
  logic [WC_W-1:0]   r_wcnt;
  logic [DATA_W-1:0] r_ans_dm;

  logic [ADDR_W-1:0] w_addr;
  logic              w_store;
  logic              w_load;
  logic              w_full;
  logic              w_empty;
  logic              w_stall;
  logic              w_push;
  logic              w_pop;
  logic              w_more;
  logic              w_hit;
  logic [DATA_W-1:0] w_fwd_data;
  logic [DATA_W-1:0] w_rdata;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [CNT_W-1:0]  w_count;

  assign w_addr  = ans_ex[ADDR_W-1:0];
  assign w_store = mem_en_ex & mem_rw_ex;
  assign w_load  = mem_en_ex & ~mem_rw_ex;
  // Full is judged on the pre-edge count, so a same-cycle pop cannot admit a store.
  assign w_stall = w_store & w_full;
  assign w_push  = w_store & ~w_full;
  assign w_pop   = (r_state == D_WRITE) && (r_wcnt == WC_W'(WR_LAT - 1));
  assign w_more  = (w_count > CNT_W'(1)) | w_push;
  assign w_rdata = w_hit ? w_fwd_data : r_mem[w_addr];

  assign ans_dm   = r_ans_dm;
  assign stall_dm = w_stall;
  assign sb_count = w_count;
  assign sb_empty = w_empty;

  dm_store_buffer #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_addr (w_addr),
    .i_push_data (DM_data),
    .i_pop       (w_pop),
    .i_lk_addr   (w_addr),
    .o_lk_hit    (w_hit),
    .o_lk_data   (w_fwd_data),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_full      (w_full)
  );

  // Array write port; the array itself is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_pop) r_mem[w_head_addr] <= w_head_data;
  end

  // Drain engine: hold the head for WR_LAT cycles, then commit and pop it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= D_IDLE;
      r_wcnt  <= {WC_W{1'b0}};
    end else begin
      case (r_state)
        D_IDLE: begin
          r_wcnt <= {WC_W{1'b0}};
          if (!w_empty) r_state <= D_WRITE;
          else          r_state <= D_IDLE;
        end
        D_WRITE: begin
          if (w_pop) begin
            r_wcnt  <= {WC_W{1'b0}};
            r_state <= w_more ? D_WRITE : D_IDLE;
          end else begin
            r_wcnt  <= r_wcnt + WC_W'(1);
            r_state <= D_WRITE;
          end
        end
        default: begin
          r_state <= D_IDLE;
          r_wcnt  <= {WC_W{1'b0}};
        end
      endcase
    end
  end

  // Result register toward WB; a refused store leaves it untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ans_dm <= {DATA_W{1'b0}};
    end else if (w_stall) begin
      r_ans_dm <= r_ans_dm;
    end else if (w_load && mem_mux_sel_dm) begin
      r_ans_dm <= w_rdata;
    end else begin
      r_ans_dm <= ans_ex;
    end
  end

endmodule

// File: tb/tb_dm_block_sb.sv
// Directed plus randomized bench for dm_block_sb against a queue-based model.
module tb_dm_block_sb;

  localparam int DW  = 16;
  localparam int DEP = 4;
  localparam int WL  = 2;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } ent_t;

  logic        clk;
  logic        reset;
  logic [15:0] ans_ex;
  logic [15:0] DM_data;
  logic        mem_en_ex;
  logic        mem_rw_ex;
  logic        mem_mux_sel_dm;
  logic [15:0] ans_dm;
  logic        stall_dm;
  logic [2:0]  sb_count;
  logic        sb_empty;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  ent_t        q[$];
  logic [15:0] mem_m [256];
  logic [15:0] ans_m;
  int          dt;

  dm_block_sb dut (
    .clk            (clk),
    .reset          (reset),
    .ans_ex         (ans_ex),
    .DM_data        (DM_data),
    .mem_en_ex      (mem_en_ex),
    .mem_rw_ex      (mem_rw_ex),
    .mem_mux_sel_dm (mem_mux_sel_dm),
    .ans_dm         (ans_dm),
    .stall_dm       (stall_dm),
    .sb_count       (sb_count),
    .sb_empty       (sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    dt    = -1;
    ans_m = 16'h0000;
  endtask

  // One clock cycle: drive, check stall, advance model across the edge, check outputs.
  task automatic step(input logic en, input logic rw, input logic sel,
                      input logic [15:0] ax, input logic [15:0] dd,
                      output logic stall_obs);
    logic [7:0]  a;
    logic [15:0] rd;
    logic        st;
    logic        popped;
    mem_en_ex      = en;
    mem_rw_ex      = rw;
    mem_mux_sel_dm = sel;
    ans_ex         = ax;
    DM_data        = dd;
    #1;
    a  = ax[7:0];
    st = en && rw && (q.size() == DEP);
    rd = mem_m[a];
    foreach (q[i]) if (q[i].a == a) rd = q[i].d;
    stall_obs = stall_dm;
    chk("stall_dm", {31'd0, stall_dm}, {31'd0, st});
    @(posedge clk);
    if (en && rw) begin
      if (!st) ans_m = ax;
    end else if (en) begin
      ans_m = sel ? rd : ax;
    end else begin
      ans_m = ax;
    end
    popped = 1'b0;
    if (dt < 0) begin
      if (q.size() > 0) dt = 0;
    end else if (dt == WL - 1) begin
      mem_m[q[0].a] = q[0].d;
      void'(q.pop_front());
      popped = 1'b1;
    end else begin
      dt++;
    end
    if (en && rw && !st) q.push_back('{a: a, d: dd});
    if (popped) dt = (q.size() > 0) ? 0 : -1;
    #1;
    chk("ans_dm", {16'd0, ans_dm}, {16'd0, ans_m});
    chk("sb_count", {29'd0, sb_count}, 32'(q.size()));
    chk("sb_empty", {31'd0, sb_empty}, {31'd0, (q.size() == 0)});
  endtask

  task automatic drain_wait();
    logic s;
    for (int g = 0; g < 40 && q.size() > 0; g++)
      step(1'b0, 1'b0, 1'b0, 16'($urandom), 16'h0000, s);
    chk("drain_done", {31'd0, sb_empty}, 32'd1);
  endtask

  initial begin
    logic        s;
    logic [15:0] ax;
    int          exp_cnt [5];
    exp_cnt = '{1, 2, 3, 3, 4};

    reset = 1'b1; mem_en_ex = 1'b0; mem_rw_ex = 1'b0; mem_mux_sel_dm = 1'b0;
    ans_ex = 16'h0000; DM_data = 16'h0000;
    model_reset();

    // Reset held across a clock edge with a store presented.
    #2;
    reset = 1'b0; ans_ex = 16'h0003; DM_data = 16'hFFFF; mem_en_ex = 1'b1; mem_rw_ex = 1'b1;
    #1;
    chk("rst_ans_dm", {16'd0, ans_dm}, 32'd0);
    chk("rst_count", {29'd0, sb_count}, 32'd0);
    chk("rst_empty", {31'd0, sb_empty}, 32'd1);
    chk("rst_stall", {31'd0, stall_dm}, 32'd0);
    @(posedge clk); #1;
    chk("rst_ans_dm_edge", {16'd0, ans_dm}, 32'd0);
    chk("rst_count_edge", {29'd0, sb_count}, 32'd0);
    chk("rst_empty_edge", {31'd0, sb_empty}, 32'd1);
    chk("rst_stall_edge", {31'd0, stall_dm}, 32'd0);
    #2;
    reset = 1'b1;

    // Store then immediate forwarded load; then load again from the array.
    step(1'b1, 1'b1, 1'b0, 16'h0003, 16'hFFFF, s);
    step(1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000, s);
    chk("t2_fwd", {16'd0, ans_dm}, 32'h0000FFFF);
    drain_wait();
    step(1'b1, 1'b0, 1'b1, 16'hFF03, 16'h0000, s);
    chk("t2_array", {16'd0, ans_dm}, 32'h0000FFFF);

    // Six back-to-back stores from an idle, empty buffer.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0020 + 16'(i), 16'(i * 7 + 1), s);
      if (i < 5) chk("t3_count", {29'd0, sb_count}, 32'(exp_cnt[i]));
      chk("t3_stall", {31'd0, s}, {31'd0, (i == 5)});
    end
    step(1'b1, 1'b1, 1'b0, 16'h0025, 16'(36), s);
    chk("t3_accept", {31'd0, s}, 32'd0);
    drain_wait();

    // Duplicate addresses: youngest wins, both forwarded and after draining.
    step(1'b1, 1'b1, 1'b0, 16'h0005, 16'h1111, s);
    step(1'b1, 1'b1, 1'b0, 16'h0005, 16'h2222, s);
    step(1'b1, 1'b0, 1'b1, 16'h0005, 16'h0000, s);
    chk("t4_fwd", {16'd0, ans_dm}, 32'h00002222);
    drain_wait();
    step(1'b1, 1'b0, 1'b1, 16'h0005, 16'h0000, s);
    chk("t4_array", {16'd0, ans_dm}, 32'h00002222);

    // Load with the mux selecting the ALU result.
    step(1'b1, 1'b0, 1'b0, 16'h00A5, 16'h0000, s);
    chk("t5_bypass", {16'd0, ans_dm}, 32'h000000A5);

    // Reset with three stores pending: they must all be lost.
    step(1'b1, 1'b1, 1'b0, 16'h0003, 16'h1234, s);
    step(1'b1, 1'b1, 1'b0, 16'h0005, 16'h5678, s);
    step(1'b1, 1'b1, 1'b0, 16'h0003, 16'h9ABC, s);
    chk("t6_pending", {29'd0, sb_count}, 32'd3);
    reset = 1'b0;
    model_reset();
    #1;
    chk("t6_count", {29'd0, sb_count}, 32'd0);
    chk("t6_empty", {31'd0, sb_empty}, 32'd1);
    chk("t6_ans", {16'd0, ans_dm}, 32'd0);
    #3;
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000, s);
    chk("t6_old3", {16'd0, ans_dm}, 32'h0000FFFF);
    step(1'b1, 1'b0, 1'b1, 16'h0005, 16'h0000, s);
    chk("t6_old5", {16'd0, ans_dm}, 32'h00002222);

    // Seed a small address window so every random load has a known value.
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 1'b0, 16'(i), 16'($urandom), s);
    drain_wait();

    // Random mix of loads, stores and idle cycles over that window.
    for (int n = 0; n < 400; n++) begin
      ax = 16'($urandom);
      ax = {ax[15:8], 5'b00000, ax[2:0]};
      step(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 6),
           1'($urandom), ax, 16'($urandom), s);
    end
    drain_wait();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
